// File: rtl/g15_pkg.sv
// Shared definitions for the G-15 style command fetch: timing defaults, command-word field positions, FSM states.
// Defining BREAKPOINT_EN adds the HALT state used for breakpoint stops.
package g15_pkg;

    localparam int WORD_BITS_DEF  = 29;
    localparam int WORD_TIMES_DEF = 108;

    // Bit-time positions of the command-word fields on the command line
    localparam int CJ_LO   = 1;
    localparam int CJ_HI   = 13;
    localparam int N_LO    = 14;
    localparam int N_HI    = 20;
    localparam int BP_BIT  = 21;
    localparam int T_LO    = 22;
    localparam int T_HI    = 28;
    localparam int FIELD_W = 7;

`ifdef BREAKPOINT_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_L = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } fetch_state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_L = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3
    } fetch_state_e;
`endif

endpackage

// File: rtl/command_fetch_serial_field_capture.sv
// One LSB-first serial field: shifts the command-line bit in while BIT_T lies in [LO, HI] and the enable is set.
module serial_field_capture
    import g15_pkg::*;
#(
    parameter int LO = N_LO,
    parameter int HI = N_HI,
    parameter int W  = FIELD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [4:0]   bit_t,
    input  logic         din,
    output logic [W-1:0] field
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;
    logic         in_window;

    // Right shift: after W shifts the first bit received sits in bit 0
    always_comb begin
        in_window = en && (bit_t >= 5'(LO)) && (bit_t <= 5'(HI));
        field_d   = field_q;
        if (in_window) begin
            field_d = {din, field_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign field = field_q;

endmodule

// File: rtl/command_fetch.sv
// Command fetch sequencer: waits for the drum to reach word L, reads the command word serially, hands off to execution.
// Optional BREAKPOINT_EN adds a HALT state entered on a flagged command when the breakpoint switch is on.
module command_fetch
    import g15_pkg::*;
#(
    parameter int WORD_BITS  = WORD_BITS_DEF,
    parameter int WORD_TIMES = WORD_TIMES_DEF
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic [4:0] BIT_T,
    input  logic [6:0] WORD_T,
    input  logic       CM,
    input  logic       START,
    input  logic       EXEC_DONE,
    input  logic       BP_SW,
    input  logic       GO,
    output logic       RC,
    output logic       CJ,
    output logic       CI,
    output logic [6:0] N_REG,
    output logic [6:0] T_REG,
    output logic       CMD_READY,
    output logic       HALTED
);

    localparam logic [4:0] LAST_BIT  = 5'(WORD_BITS - 1);
    localparam logic [6:0] LAST_WORD = 7'(WORD_TIMES - 1);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [6:0]   l_q;
    logic [6:0]   l_d;
    logic         bp_q;
    logic         bp_d;
    logic         cj_q;
    logic         cj_d;
    logic         cmd_ready_q;
    logic         cmd_ready_d;
    logic [6:0]   next_word;
    logic [4:0]   next_bit;
    logic         reading;

    // The drum timing counters are the only time base; these give the position of the next bit time
    assign next_word = (WORD_T == LAST_WORD) ? 7'd0 : WORD_T + 7'd1;
    assign next_bit  = (BIT_T == LAST_BIT) ? 5'd0 : BIT_T + 5'd1;
    assign reading   = (state_q == READ);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = WAIT_L;
                end
            end
            WAIT_L: begin
                // Leaving at the last bit of word L-1 makes READ start exactly at bit 0 of word L
                if ((BIT_T == LAST_BIT) && (next_word == l_q)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (BIT_T == LAST_BIT) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (EXEC_DONE) begin
`ifdef BREAKPOINT_EN
                    state_d = (bp_q && BP_SW) ? HALT : WAIT_L;
`else
                    state_d = WAIT_L;
`endif
                end
            end
`ifdef BREAKPOINT_EN
            HALT: begin
                if (GO) begin
                    state_d = WAIT_L;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        l_d  = l_q;
        bp_d = bp_q;
        if ((state_q == EXEC) && EXEC_DONE) begin
            l_d = N_REG;
        end
        if (reading && (BIT_T == 5'(BP_BIT))) begin
            bp_d = CM;
        end
    end

    // CJ is registered one bit time ahead so that CI = CM & CJ lines up with the current CM bit
    always_comb begin
        cj_d        = (state_d == READ) && (next_bit >= 5'(CJ_LO)) && (next_bit <= 5'(CJ_HI));
        cmd_ready_d = reading && (state_d == EXEC);
        RC          = reading;
`ifdef BREAKPOINT_EN
        HALTED      = (state_q == HALT);
`else
        HALTED      = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            l_q         <= '0;
            bp_q        <= 1'b0;
            cj_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            l_q         <= l_d;
            bp_q        <= bp_d;
            cj_q        <= cj_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign CJ        = cj_q;
    assign CI        = CM & cj_q;
    assign CMD_READY = cmd_ready_q;

`ifndef BREAKPOINT_EN
    logic unused_bp;
    assign unused_bp = bp_q ^ BP_SW ^ GO;
`endif

    serial_field_capture #(
        .LO (N_LO),
        .HI (N_HI),
        .W  (FIELD_W)
    ) u_n_field (
        .clk   (CLOCK),
        .rst_n (rst_n),
        .en    (reading),
        .bit_t (BIT_T),
        .din   (CM),
        .field (N_REG)
    );

    serial_field_capture #(
        .LO (T_LO),
        .HI (T_HI),
        .W  (FIELD_W)
    ) u_t_field (
        .clk   (CLOCK),
        .rst_n (rst_n),
        .en    (reading),
        .bit_t (BIT_T),
        .din   (CM),
        .field (T_REG)
    );

endmodule

// File: doc/command_fetch.md
COMMAND_FETCH -- requirements
Module: command_fetch

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- WORD_BITS, 29, bit times per word.
- WORD_TIMES, 108, word times per drum revolution.
REQ-002 Ports (name direction width meaning), in this order:
- CLOCK in 1 bit-time clock.
- rst_n in 1 reset; asynchronous, active-low.
- BIT_T in 5 current bit time, 0..WORD_BITS-1.
- WORD_T in 7 current word time, 0..WORD_TIMES-1.
- CM in 1 serial command-line data bit for the current BIT_T.
- START in 1 one-cycle pulse that begins fetching.
- EXEC_DONE in 1 one-cycle pulse: command execution complete.
- BP_SW in 1 breakpoint switch.
- GO in 1 one-cycle pulse that resumes from breakpoint halt.
- RC out 1 read-command phase active.
- CJ out 1 command-register shift gate.
- CI out 1 serial command bit to command register.
- N_REG out 7 captured next-command word time.
- T_REG out 7 captured timing field.
- CMD_READY out 1 one-cycle pulse: command register loaded.
- HALTED out 1 breakpoint halt active.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_L, READ, EXEC, HALT; all outputs SHALL be registered or decoded from the state and registers only, except CI.
REQ-004 An internal 7-bit L register SHALL hold the word time of the next command.
REQ-005 In IDLE, START SHALL move the FSM to WAIT_L. START SHALL be ignored in all other states.
REQ-006 In WAIT_L, when BIT_T==WORD_BITS-1 and (WORD_T+1) mod WORD_TIMES==L, the FSM SHALL enter READ, so that READ begins at bit 0 of word L (L=0 matches WORD_T=107).
REQ-007 RC SHALL be 1 exactly while in READ, i.e. for WORD_BITS cycles.
REQ-008 CJ SHALL be 1 in READ for BIT_T 1..13.
REQ-009 CI SHALL be CM AND CJ, combinational, so it is valid in the same cycle as CJ.
REQ-010 The CM bit at BIT_T 0 SHALL be ignored.
REQ-011 Field capture in READ:
- BIT_T 14..20 SHALL shift into N_REG, LSB first.
- BIT_T 21 SHALL be captured as the breakpoint flag BP.
- BIT_T 22..28 SHALL shift into T_REG, LSB first.
REQ-012 At BIT_T==WORD_BITS-1 in READ, the FSM SHALL enter EXEC. CMD_READY SHALL be 1 for the first EXEC cycle only.
REQ-013 In EXEC, EXEC_DONE SHALL be sampled every cycle, including the first. On EXEC_DONE:
- L SHALL take N_REG.
- The FSM SHALL go to WAIT_L, or to HALT per REQ-018.
REQ-014 Values of N_REG from 108 to 127 SHALL be loaded into L unchanged. They never match, so the FSM SHALL stay in WAIT_L until reset.
REQ-015 EXEC_DONE and GO SHALL be ignored outside EXEC and HALT respectively.
REQ-016 The FSM SHALL follow BIT_T and WORD_T directly. It SHALL keep no private bit counter.

Reset
REQ-017 While rst_n is 0, asynchronously:
- The state SHALL be IDLE.
- L, N_REG, T_REG and BP SHALL be 0.
- RC, CJ, CI, CMD_READY and HALTED SHALL be 0.
- A reset mid-READ SHALL discard partial fields.
- After release, a START SHALL be required before any fetch.

Configuration
REQ-018 With macro BREAKPOINT_EN defined:
- On EXEC_DONE with BP==1 and BP_SW==1, the FSM SHALL enter HALT.
- HALTED SHALL be 1 while in HALT.
- GO SHALL move the FSM from HALT to WAIT_L.
Without BREAKPOINT_EN:
- The HALT state SHALL be absent.
- BP SHALL be captured but unused.
- BP_SW and GO SHALL be present but ignored.
- HALTED SHALL be tied 0.

Structure
REQ-019 A shared package g15_pkg SHALL hold:
- the WORD_BITS and WORD_TIMES defaults;
- the command-field bit positions (CJ 1..13, N 14..20, BP 21, T 22..28);
- the FSM state enum.
REQ-020 A sub-module serial_field_capture SHALL implement one 7-bit LSB-first shift field enabled over a BIT_T window. It SHALL be instantiated twice, once for N_REG and once for T_REG.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, START, L=0 -> RC rises after WORD_T=107/BIT_T=28 and stays 1 for 29 cycles; CJ is 1 for bits 1..13; CI equals CM there.
- Command with N=5, T=51 -> N_REG=5, T_REG=51, a single CMD_READY pulse; after EXEC_DONE the next RC starts at word 5 bit 0.
- Command read at word 107 with N=0 -> the next fetch starts at WORD_T=0 of the following revolution.
- rst_n low at READ bit 10 -> RC, CJ, CI immediately 0, N_REG=0, FSM in IDLE; no RC until START.
- BP=1 and BP_SW=1 with BREAKPOINT_EN -> HALTED=1 after EXEC_DONE, no RC until GO. Without BREAKPOINT_EN -> fetch continues and HALTED=0.
- N=120 -> RC never asserts over two full revolutions (6264 cycles).
